// File: rtl/sign_mutex_pkg.sv
// Shared types for the sign mutex: the class/state encoding and its one-hot flag decode.
package sign_mutex_pkg;

  typedef enum logic [1:0] {
    S_ZERO = 2'b00,
    S_POS  = 2'b01,
    S_NEG  = 2'b10
  } sign_t;

  // Flag vectors are ordered {positive, negative, zero}.
  localparam logic [2:0] FLAGS_ZERO = 3'b001;
  localparam logic [2:0] FLAGS_POS  = 3'b100;
  localparam logic [2:0] FLAGS_NEG  = 3'b010;

  function automatic logic [2:0] flags_of(sign_t s);
    case (s)
      S_POS:   return FLAGS_POS;
      S_NEG:   return FLAGS_NEG;
      default: return FLAGS_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/sign_classify.sv
// Combinational sign classifier: zero, negative (MSB set) or positive.
module sign_classify
  import sign_mutex_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] sample,
  output sign_t            cls
);

  always_comb begin
    if (sample == '0)
      cls = S_ZERO;
    else if (sample[WIDTH-1])
      cls = S_NEG;
    else
      cls = S_POS;
  end

endmodule

// File: rtl/sign_mutex_fsm.sv
// Debounced sign tracker: the state moves to a new sign class only after CONFIRM
// consecutive qualifying samples of that class; counts changes with saturation.
module sign_mutex_fsm
  import sign_mutex_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int CONFIRM = 2,
  parameter int CNT_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] in,
  input  logic                    clear,
  output logic                    positive_flag,
  output logic                    negative_flag,
  output logic                    zero_flag,
  output logic                    change_pulse,
  output logic [CNT_W-1:0]        flip_count
);

  localparam int RUN_W = $clog2(CONFIRM + 1);
  localparam logic [RUN_W:0] CONFIRM_V = (RUN_W + 1)'(CONFIRM);

  sign_t            cls;
  sign_t            state, state_n;
  sign_t            cand, cand_n;
  logic [RUN_W-1:0] run, run_n;
  logic [RUN_W:0]   run_inc;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             pulse, pulse_n;
  logic [2:0]       flags, flags_n;

  sign_classify #(.WIDTH(WIDTH)) u_classify (
    .sample (in),
    .cls    (cls)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_ZERO;
      cand  <= S_ZERO;
      run   <= '0;
      cnt   <= '0;
      pulse <= 1'b0;
      flags <= FLAGS_ZERO;
    end else begin
      state <= state_n;
      cand  <= cand_n;
      run   <= run_n;
      cnt   <= cnt_n;
      pulse <= pulse_n;
      flags <= flags_n;
    end
  end

  always_comb begin
    state_n = state;
    cand_n  = cand;
    run_n   = run;
    cnt_n   = cnt;
    pulse_n = 1'b0;
    // Computed one bit wider so run+1 == CONFIRM is never lost to truncation.
    run_inc = (cls == cand) ? ({1'b0, run} + (RUN_W + 1)'(1)) : (RUN_W + 1)'(1);
    if (clear) begin
      run_n  = '0;
      cand_n = S_ZERO;
      cnt_n  = '0;
    end else if (in_valid) begin
      if (cls == state) begin
        run_n = '0;
      end else begin
        cand_n = cls;
        if (run_inc == CONFIRM_V) begin
          state_n = cls;
          run_n   = '0;
          pulse_n = 1'b1;
          if (cnt != '1)
            cnt_n = cnt + CNT_W'(1);
        end else begin
          run_n = run_inc[RUN_W-1:0];
        end
      end
    end
    flags_n = flags_of(state_n);
  end

  assign {positive_flag, negative_flag, zero_flag} = flags;
  assign change_pulse = pulse;
  assign flip_count   = cnt;

endmodule

// File: tb/tb_sign_mutex_fsm.sv
// Scoreboard bench: directed steps queue hand-computed expectations, a monitor checks each cycle.
module tb_sign_mutex_fsm;

  localparam logic [2:0] P = 3'b100;
  localparam logic [2:0] N = 3'b010;
  localparam logic [2:0] Z = 3'b001;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               clear = 1'b0;
  logic signed [15:0] in_s = '0;

  logic       pos1, neg1, zero1, chg1;
  logic [7:0] cnt1;
  logic       pos2, neg2, zero2, chg2;
  logic [1:0] cnt2;

  typedef struct {
    string      name;
    logic [2:0] f;
    logic       p;
    logic [7:0] c;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  sign_mutex_fsm #(.WIDTH(16), .CONFIRM(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in(in_s), .clear(clear),
    .positive_flag(pos1), .negative_flag(neg1), .zero_flag(zero1),
    .change_pulse(chg1), .flip_count(cnt1)
  );

  sign_mutex_fsm #(.WIDTH(16), .CONFIRM(2), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in(in_s), .clear(clear),
    .positive_flag(pos2), .negative_flag(neg2), .zero_flag(zero2),
    .change_pulse(chg2), .flip_count(cnt2)
  );

  function automatic void chk(string name, logic [7:0] got, logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endfunction

  task automatic step(string name, logic v, logic [15:0] d, logic clr,
                      logic [2:0] f, logic p, logic [7:0] c);
    exp_t e;
    @(negedge clk);
    in_valid = v;
    in_s     = d;
    clear    = clr;
    e.name = name;
    e.f    = f;
    e.p    = p;
    e.c    = c;
    q.push_back(e);
  endtask

  // Monitor: every cycle that has a queued expectation is checked one step after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.name, ".flags"},  {5'b0, pos1, neg1, zero1}, {5'b0, e.f});
        chk({e.name, ".pulse"},  {7'b0, chg1}, {7'b0, e.p});
        chk({e.name, ".count"},  cnt1, e.c);
        chk({e.name, ".flags2"}, {5'b0, pos2, neg2, zero2}, {5'b0, e.f});
        chk({e.name, ".pulse2"}, {7'b0, chg2}, {7'b0, e.p});
        chk({e.name, ".count2"}, {6'b0, cnt2}, (e.c > 8'd3) ? 8'd3 : e.c);
        chk({e.name, ".onehot"}, {7'b0, $onehot({pos1, neg1, zero1})}, 8'd1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.flags", {5'b0, pos1, neg1, zero1}, {5'b0, Z});
    chk("reset.pulse", {7'b0, chg1}, 8'd0);
    chk("reset.count", cnt1, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Two samples of +10 confirm POS; pulse lasts one cycle.
    step("pos1", 1'b1, 16'd10, 1'b0, Z, 1'b0, 8'd1 - 8'd1);
    step("pos2", 1'b1, 16'd10, 1'b0, P, 1'b1, 8'd1);
    step("idle", 1'b0, 16'd0,  1'b0, P, 1'b0, 8'd1);

    // Alternating non-state classes never confirm.
    step("alt-5a", 1'b1, 16'hFFFB, 1'b0, P, 1'b0, 8'd1);
    step("alt10",  1'b1, 16'd10,   1'b0, P, 1'b0, 8'd1);
    step("alt-5b", 1'b1, 16'hFFFB, 1'b0, P, 1'b0, 8'd1);
    step("alt0",   1'b1, 16'd0,    1'b0, P, 1'b0, 8'd1);
    step("alt-5c", 1'b1, 16'hFFFB, 1'b0, P, 1'b0, 8'd1);
    step("alt10b", 1'b1, 16'd10,   1'b0, P, 1'b0, 8'd1);

    // Boundary values, including a direct POS->NEG change.
    step("min_a", 1'b1, 16'h8000, 1'b0, P, 1'b0, 8'd1);
    step("min_b", 1'b1, 16'h8000, 1'b0, N, 1'b1, 8'd2);
    step("z_a",   1'b1, 16'h0000, 1'b0, N, 1'b0, 8'd2);
    step("z_b",   1'b1, 16'h0000, 1'b0, Z, 1'b1, 8'd3);
    step("max_a", 1'b1, 16'h7FFF, 1'b0, Z, 1'b0, 8'd3);
    step("max_b", 1'b1, 16'h7FFF, 1'b0, P, 1'b1, 8'd4);
    step("pn_a",  1'b1, 16'h8000, 1'b0, P, 1'b0, 8'd4);
    step("pn_b",  1'b1, 16'h8000, 1'b0, N, 1'b1, 8'd5);

    // Invalid gaps do not break a run.
    step("gz_a",  1'b1, 16'd0,     1'b0, N, 1'b0, 8'd5);
    step("gz_b",  1'b1, 16'd0,     1'b0, Z, 1'b1, 8'd6);
    step("gap_1", 1'b1, 16'hFFFB,  1'b0, Z, 1'b0, 8'd6);
    step("gap_i1", 1'b0, 16'd7,    1'b0, Z, 1'b0, 8'd6);
    step("gap_i2", 1'b0, 16'd7,    1'b0, Z, 1'b0, 8'd6);
    step("gap_i3", 1'b0, 16'd7,    1'b0, Z, 1'b0, 8'd6);
    step("gap_2", 1'b1, 16'hFFFB,  1'b0, N, 1'b1, 8'd7);

    // Clear drops count, run and candidate; flags hold; its sample is ignored.
    step("cl_a",  1'b1, 16'd0, 1'b0, N, 1'b0, 8'd7);
    step("cl_b",  1'b1, 16'd0, 1'b1, N, 1'b0, 8'd0);
    step("cl_c",  1'b1, 16'd0, 1'b0, N, 1'b0, 8'd0);
    step("cl_d",  1'b1, 16'd0, 1'b0, Z, 1'b1, 8'd1);
    step("cl_e",  1'b1, 16'd10, 1'b0, Z, 1'b0, 8'd1);
    step("cl_f",  1'b1, 16'd10, 1'b1, Z, 1'b0, 8'd0);
    step("cl_g",  1'b1, 16'd10, 1'b0, Z, 1'b0, 8'd0);
    step("cl_h",  1'b1, 16'd10, 1'b0, P, 1'b1, 8'd1);

    // Asynchronous reset between edges while a NEG run is pending.
    step("rst_pre", 1'b1, 16'hFFFB, 1'b0, P, 1'b0, 8'd1);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst.zero",  {7'b0, zero1}, 8'd1);
    chk("arst.pos",   {7'b0, pos1},  8'd0);
    chk("arst.count", cnt1, 8'd0);
    chk("arst.count2", {6'b0, cnt2}, 8'd0);
    chk("arst.pulse", {7'b0, chg1},  8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_a", 1'b1, 16'hFFFB, 1'b0, Z, 1'b0, 8'd0);
    step("post_b", 1'b1, 16'hFFFB, 1'b0, N, 1'b1, 8'd1);
    step("tail",   1'b0, 16'd0,    1'b0, N, 1'b0, 8'd1);

    n = 0;
    while (q.size() > 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #2;
    chk("drain", 8'(q.size()), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
